// File: rtl/mux_scan_ctrl.sv
// Scans a 16:1 mux, keeps a shadow copy of each channel and raises sticky change flags / interrupt.
// Optional SCAN_DEBOUNCE_EN: a change must be seen on two consecutive sweeps before it is accepted.
module mux_scan_ctrl #(
  parameter int unsigned n     = 8,
  parameter int unsigned DWELL = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  output logic [3:0]   SEL,
  input  logic [n-1:0] D_IN,
  input  logic [3:0]   RD_ADDR,
  output logic [n-1:0] RD_DATA,
  output logic [15:0]  CHG_FLAGS,
  output logic         INTR,
  input  logic         INTR_ACK,
  output logic         SCAN_DONE
);

  localparam int unsigned NCH   = 16;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [n-1:0]       shadow [NCH];
  logic [15:0]        flags_nxt;
  logic               sample_c;
  logic               cnt_clr_c;
  logic               done_nxt_c;
  logic               upd_c;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: once a channel starts settling it always completes its sample
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (EN) state_nxt = SETTLE;
      SETTLE:  if (cnt == CNT_W'(DWELL - 1)) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = EN ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded controls
  always_comb begin
    sample_c   = 1'b0;
    cnt_clr_c  = 1'b0;
    done_nxt_c = 1'b0;
    sample_c   = (state == SAMPLE);
    cnt_clr_c  = (state_nxt == SETTLE) && (state != SETTLE);
    done_nxt_c = (state_nxt == SAMPLE) && (SEL == 4'hF);
  end

`ifdef SCAN_DEBOUNCE_EN
  logic [n-1:0] cand [NCH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) cand[i] <= '0;
    end else if (sample_c) begin
      cand[SEL] <= D_IN;
    end
  end

  always_comb upd_c = sample_c && (D_IN == cand[SEL]) && (D_IN != shadow[SEL]);
`else
  always_comb upd_c = sample_c && (D_IN != shadow[SEL]);
`endif

  // Acknowledge clears everything, but a flag raised in the same cycle survives
  always_comb begin
    flags_nxt = INTR_ACK ? 16'h0000 : CHG_FLAGS;
    if (upd_c) flags_nxt[SEL] = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      SEL       <= '0;
      CHG_FLAGS <= '0;
      INTR      <= 1'b0;
      SCAN_DONE <= 1'b0;
      for (int i = 0; i < NCH; i++) shadow[i] <= '0;
    end else begin
      if (cnt_clr_c)            cnt <= '0;
      else if (state == SETTLE) cnt <= cnt + CNT_W'(1);
      if (sample_c)             SEL <= SEL + 4'd1;
      if (upd_c)                shadow[SEL] <= D_IN;
      CHG_FLAGS <= flags_nxt;
      INTR      <= |CHG_FLAGS;
      SCAN_DONE <= done_nxt_c;
    end
  end

  assign RD_DATA = shadow[RD_ADDR];

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl; models the external 16:1 mux from a per-channel value table.
module tb_mux_scan_ctrl;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic [3:0]  SEL;
  logic [7:0]  D_IN;
  logic [3:0]  RD_ADDR;
  logic [7:0]  RD_DATA;
  logic [15:0] CHG_FLAGS;
  logic        INTR;
  logic        INTR_ACK;
  logic        SCAN_DONE;

  logic [7:0]  chan [16];
  int          n_checks;
  int          n_fail;
  int          cyc;

  mux_scan_ctrl #(.n(8), .DWELL(2)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .SEL(SEL), .D_IN(D_IN),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .CHG_FLAGS(CHG_FLAGS),
    .INTR(INTR), .INTR_ACK(INTR_ACK), .SCAN_DONE(SCAN_DONE)
  );

  assign D_IN = chan[SEL];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Cycle index k: sampled at the falling edge after the k-th rising edge since reset release
  task automatic step();
    @(negedge CLK);
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; INTR_ACK = 1'b0; RD_ADDR = 4'd0;
    for (int i = 0; i < 16; i++) chan[i] = 8'h00;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0; EN = 1'b1;
    cyc = -1;
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; INTR_ACK = 1'b0; RD_ADDR = 4'd0;
    for (int i = 0; i < 16; i++) chan[i] = 8'h00;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (SEL !== 4'd0) begin n_fail++; $display("FAIL reset_sel: got %0h expected 0", SEL); end
    n_checks++;
    if (CHG_FLAGS !== 16'h0) begin n_fail++; $display("FAIL reset_flags: got %0h expected 0", CHG_FLAGS); end
    n_checks++;
    if (INTR !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %0b expected 0", INTR); end
    n_checks++;
    if (SCAN_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", SCAN_DONE); end
    for (int a = 0; a < 16; a++) begin
      RD_ADDR = 4'(a); #1;
      n_checks++;
      if (RD_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_rd[%0d]: got %0h expected 0", a, RD_DATA); end
    end
  endtask

  task automatic test_sweep();
    do_reset();
    for (int k = 0; k <= 50; k++) begin
      step();
      n_checks++;
      if (SEL !== 4'((k / 3) % 16)) begin n_fail++; $display("FAIL sweep_sel k=%0d: got %0d expected %0d", k, SEL, (k / 3) % 16); end
      n_checks++;
      if (SCAN_DONE !== (k == 47)) begin n_fail++; $display("FAIL sweep_done k=%0d: got %0b expected %0b", k, SCAN_DONE, k == 47); end
      n_checks++;
      if (CHG_FLAGS !== 16'h0 || INTR !== 1'b0) begin n_fail++; $display("FAIL sweep_quiet k=%0d: flags %0h intr %0b expected 0 0", k, CHG_FLAGS, INTR); end
    end
  endtask

  task automatic test_change();
    do_reset();
    chan[5] = 8'hA5;
    step_to(17);
    n_checks++;
    if (CHG_FLAGS !== 16'h0) begin n_fail++; $display("FAIL chg_pre: got %0h expected 0", CHG_FLAGS); end
    step_to(18);
    RD_ADDR = 4'd5; #1;
    n_checks++;
    if (CHG_FLAGS !== 16'h0020) begin n_fail++; $display("FAIL chg_flags: got %0h expected 0020", CHG_FLAGS); end
    n_checks++;
    if (INTR !== 1'b0) begin n_fail++; $display("FAIL chg_intr_lag: got %0b expected 0", INTR); end
    n_checks++;
    if (RD_DATA !== 8'hA5) begin n_fail++; $display("FAIL chg_rd: got %0h expected a5", RD_DATA); end
    step_to(19);
    n_checks++;
    if (INTR !== 1'b1) begin n_fail++; $display("FAIL chg_intr: got %0b expected 1", INTR); end
    INTR_ACK = 1'b1;
    step_to(20);
    INTR_ACK = 1'b0;
    n_checks++;
    if (CHG_FLAGS !== 16'h0) begin n_fail++; $display("FAIL ack_flags: got %0h expected 0", CHG_FLAGS); end
    step_to(21);
    n_checks++;
    if (INTR !== 1'b0) begin n_fail++; $display("FAIL ack_intr: got %0b expected 0", INTR); end
    step_to(70);
    n_checks++;
    if (CHG_FLAGS !== 16'h0) begin n_fail++; $display("FAIL chg_resample: got %0h expected 0", CHG_FLAGS); end
  endtask

  task automatic test_ack_collision();
    do_reset();
    chan[5] = 8'hA5;
    step_to(30);
    chan[3] = 8'h3C;
    n_checks++;
    if (CHG_FLAGS !== 16'h0020 || INTR !== 1'b1) begin n_fail++; $display("FAIL col_pre: flags %0h intr %0b expected 0020 1", CHG_FLAGS, INTR); end
    step_to(59);
    INTR_ACK = 1'b1;
    step_to(60);
    INTR_ACK = 1'b0;
    RD_ADDR = 4'd3; #1;
    n_checks++;
    if (CHG_FLAGS !== 16'h0008) begin n_fail++; $display("FAIL col_flags: got %0h expected 0008", CHG_FLAGS); end
    n_checks++;
    if (INTR !== 1'b1) begin n_fail++; $display("FAIL col_intr0: got %0b expected 1", INTR); end
    n_checks++;
    if (RD_DATA !== 8'h3C) begin n_fail++; $display("FAIL col_rd: got %0h expected 3c", RD_DATA); end
    step_to(61);
    n_checks++;
    if (INTR !== 1'b1) begin n_fail++; $display("FAIL col_intr1: got %0b expected 1", INTR); end
  endtask

  task automatic test_en_drop();
    do_reset();
    chan[7] = 8'h77;
    chan[8] = 8'h88;
    step_to(21);
    n_checks++;
    if (SEL !== 4'd7) begin n_fail++; $display("FAIL drop_sel7: got %0d expected 7", SEL); end
    EN = 1'b0;
    step_to(24);
    n_checks++;
    if (SEL !== 4'd8 || CHG_FLAGS !== 16'h0080) begin n_fail++; $display("FAIL drop_sample7: sel %0d flags %0h expected 8 0080", SEL, CHG_FLAGS); end
    step_to(28);
    n_checks++;
    if (SEL !== 4'd8 || CHG_FLAGS !== 16'h0080) begin n_fail++; $display("FAIL drop_idle: sel %0d flags %0h expected 8 0080", SEL, CHG_FLAGS); end
    EN = 1'b1;
    step_to(30);
    n_checks++;
    if (SEL !== 4'd8) begin n_fail++; $display("FAIL resume_sel: got %0d expected 8", SEL); end
    step_to(32);
    n_checks++;
    if (SEL !== 4'd9 || CHG_FLAGS !== 16'h0180) begin n_fail++; $display("FAIL resume_sample8: sel %0d flags %0h expected 9 0180", SEL, CHG_FLAGS); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    chan[0] = 8'h01; chan[4] = 8'h44; chan[10] = 8'hAA;
    step_to(76);
    chan[10] = 8'h55;
    RD_ADDR = 4'd10; #1;
    n_checks++;
    if (RD_DATA !== 8'hAA) begin n_fail++; $display("FAIL mid_loaded: got %0h expected aa", RD_DATA); end
    step_to(78);
    n_checks++;
    if (SEL !== 4'd10) begin n_fail++; $display("FAIL mid_sel10: got %0d expected 10", SEL); end
    RST = 1'b1; #1;
    n_checks++;
    if (SEL !== 4'd0 || CHG_FLAGS !== 16'h0 || INTR !== 1'b0 || SCAN_DONE !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: sel %0d flags %0h intr %0b done %0b expected 0 0 0 0", SEL, CHG_FLAGS, INTR, SCAN_DONE);
    end
    for (int a = 0; a < 16; a++) begin
      RD_ADDR = 4'(a); #1;
      n_checks++;
      if (RD_DATA !== 8'h00) begin n_fail++; $display("FAIL mid_rd[%0d]: got %0h expected 0", a, RD_DATA); end
    end
    @(negedge CLK);
    RST = 1'b0;
    cyc = -1;
    step_to(3);
    n_checks++;
    if (CHG_FLAGS !== 16'h0001) begin n_fail++; $display("FAIL post_first: got %0h expected 0001", CHG_FLAGS); end
  endtask

`ifdef SCAN_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset();
    chan[2] = 8'h11;
    step_to(20);
    chan[2] = 8'h00;
    step_to(57);
    n_checks++;
    if (CHG_FLAGS !== 16'h0) begin n_fail++; $display("FAIL db_glitch: got %0h expected 0", CHG_FLAGS); end
    step_to(60);
    chan[2] = 8'h11;
    step_to(105);
    n_checks++;
    if (CHG_FLAGS !== 16'h0) begin n_fail++; $display("FAIL db_first: got %0h expected 0", CHG_FLAGS); end
    step_to(153);
    RD_ADDR = 4'd2; #1;
    n_checks++;
    if (CHG_FLAGS !== 16'h0004 || RD_DATA !== 8'h11) begin n_fail++; $display("FAIL db_second: flags %0h rd %0h expected 0004 11", CHG_FLAGS, RD_DATA); end
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    test_reset();
    test_sweep();
`ifdef SCAN_DEBOUNCE_EN
    test_debounce();
`else
    test_change();
    test_ack_collision();
    test_en_drop();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
